// File: rtl/gnss_host_master.sv
// gnss_host_master: host-bus initiator that services the baseband interrupt.
// On irq it reads the global flag register, write-1-clears the flags it saw,
// reports them as an event and, on data-ready, streams a window of buffer
// words out over a valid/ready interface.
module gnss_host_master #(
  parameter logic [13:0] FLAG_ADDR  = 14'h0004,
  parameter int          FLAG_LSB   = 8,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        enable,
  input  logic        irq,
  input  logic [13:0] buf_base_addr,
  input  logic [7:0]  buf_words,
  output logic        host_cs,
  output logic        host_rd,
  output logic        host_wr,
  output logic [13:0] host_addr,
  output logic [31:0] host_d4wt,
  input  logic [31:0] host_d4rd,
  output logic        event_valid,
  output logic [3:0]  event_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_FLAG,
    WAIT_FLAG,
    WR_CLR,
    RD_BUF,
    WAIT_BUF,
    PUSH
  } state_t;

  // Last wait-counter value before read data is valid on host_d4rd.
  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  state_t      state;
  logic [1:0]  wait_cnt;
  logic [7:0]  idx;
  logic [13:0] cfg_base;
  logic [7:0]  cfg_words;

  logic [3:0]  rd_flags;
  logic [31:0] clr_word;
  logic [13:0] next_addr;

  // Flag field of the current read word, its write-1-clear image, and the
  // buffer address of the word after the current one (wraps mod 2^14).
  assign rd_flags  = host_d4rd[FLAG_LSB +: 4];
  assign clr_word  = {28'd0, rd_flags} << FLAG_LSB;
  assign next_addr = cfg_base + 14'(idx) + 14'd1;

  // Service FSM; every output is registered and set on entry to its state.
  // NOTE: the reset branch is asynchronous so a mid-burst reset clears the
  // bus strobes immediately instead of waiting for the next clock edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      idx         <= '0;
      cfg_base    <= '0;
      cfg_words   <= '0;
      host_cs     <= 1'b0;
      host_rd     <= 1'b0;
      host_wr     <= 1'b0;
      host_addr   <= '0;
      host_d4wt   <= '0;
      event_valid <= 1'b0;
      event_flags <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: strobes and bus fields default to 0 every cycle, so each state
      // only names what it drives; this keeps accesses single-cycle and
      // leaves the bus at 0 between accesses.
      host_cs     <= 1'b0;
      host_rd     <= 1'b0;
      host_wr     <= 1'b0;
      host_addr   <= '0;
      host_d4wt   <= '0;
      event_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && irq) begin
            state     <= RD_FLAG;
            busy      <= 1'b1;
            host_cs   <= 1'b1;
            host_rd   <= 1'b1;
            host_addr <= FLAG_ADDR;
          end
        end

        RD_FLAG: begin
          state    <= WAIT_FLAG;
          wait_cnt <= '0;
        end

        WAIT_FLAG: begin
          if (wait_cnt == LAST_WAIT) begin
            if (rd_flags == 4'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state       <= WR_CLR;
              host_cs     <= 1'b1;
              host_wr     <= 1'b1;
              host_addr   <= FLAG_ADDR;
              host_d4wt   <= clr_word;
              event_valid <= 1'b1;
              event_flags <= rd_flags;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        WR_CLR: begin
          cfg_base  <= buf_base_addr;
          cfg_words <= buf_words;
          if (event_flags[0] && (buf_words != 8'd0)) begin
            state     <= RD_BUF;
            idx       <= '0;
            host_cs   <= 1'b1;
            host_rd   <= 1'b1;
            host_addr <= buf_base_addr;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RD_BUF: begin
          state    <= WAIT_BUF;
          wait_cnt <= '0;
        end

        WAIT_BUF: begin
          if (wait_cnt == LAST_WAIT) begin
            state     <= PUSH;
            out_valid <= 1'b1;
            out_data  <= host_d4rd;
            out_last  <= (idx == cfg_words - 8'd1);
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= RD_BUF;
              idx       <= idx + 8'd1;
              host_cs   <= 1'b1;
              host_rd   <= 1'b1;
              host_addr <= next_addr;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnss_host_master.sv
// tb_gnss_host_master: table vectors, hand-written corner sequences and a
// randomized phase, all checked against a transaction-level model of the
// expected bus accesses, events and stream words.
module tb_gnss_host_master;

  localparam logic [13:0] FLAG_ADDR = 14'h0004;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        enable = 1'b0;
  logic        irq;
  logic [13:0] buf_base_addr = '0;
  logic [7:0]  buf_words = '0;
  logic        host_cs, host_rd, host_wr;
  logic [13:0] host_addr;
  logic [31:0] host_d4wt;
  logic [31:0] host_d4rd = '0;
  logic        event_valid;
  logic [3:0]  event_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  gnss_host_master #(
    .FLAG_ADDR  (FLAG_ADDR),
    .FLAG_LSB   (8),
    .RD_LATENCY (1)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .enable        (enable),
    .irq           (irq),
    .buf_base_addr (buf_base_addr),
    .buf_words     (buf_words),
    .host_cs       (host_cs),
    .host_rd       (host_rd),
    .host_wr       (host_wr),
    .host_addr     (host_addr),
    .host_d4wt     (host_d4wt),
    .host_d4rd     (host_d4rd),
    .event_valid   (event_valid),
    .event_flags   (event_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buffer contents of the responder, distinct per address.
  function automatic logic [31:0] ram_word(input logic [13:0] a);
    return {a, 2'b10, a ^ 14'h1555, 2'b01};
  endfunction

  // ---------------- responder model ----------------
  logic [3:0]  flag_reg = '0;
  logic [3:0]  hw_set = '0;
  logic        irq_force = 1'b0;
  logic [31:0] flag_junk = '0;

  assign irq = (|flag_reg) | irq_force;

  always @(posedge clk) begin
    if (host_rd)
      host_d4rd <= (host_addr == FLAG_ADDR) ? (flag_junk | ({28'd0, flag_reg} << 8))
                                            : ram_word(host_addr);
    flag_reg <= (flag_reg & ~((host_wr && host_addr == FLAG_ADDR) ? host_d4wt[11:8] : 4'h0))
                | hw_set;
  end

  // ---------------- stream ready driver ----------------
  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // ---------------- monitor ----------------
  logic [13:0] rd_log[$];
  logic [45:0] wr_log[$];
  logic [3:0]  ev_log[$];
  logic [32:0] out_log[$];
  int          busy_cycles = 0;
  int          viol = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  always @(negedge clk) begin
    if (!rst_b) begin
      prev_stall = 1'b0;
    end else begin
      if (host_rd) rd_log.push_back(host_addr);
      if (host_wr) wr_log.push_back({host_addr, host_d4wt});
      if (event_valid) ev_log.push_back(event_flags);
      if (out_valid && out_ready) out_log.push_back({out_last, out_data});
      if (busy) busy_cycles++;
      if (host_rd && host_wr) viol++;
      if (host_cs != (host_rd | host_wr)) viol++;
      if (!host_cs && (host_addr != 14'd0 || host_d4wt != 32'd0)) viol++;
      if (out_valid && host_rd) viol++;
      if (prev_stall && !(out_valid && {out_last, out_data} == prev_out)) viol++;
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    ev_log.delete();
    out_log.delete();
    busy_cycles = 0;
  endtask

  // Raise an interrupt: flags set in the responder, or a bare irq pulse
  // (held until the master starts) when the flag register reads 0.
  task automatic raise(input logic [3:0] f);
    if (f == 4'd0) begin
      irq_force = 1'b1;
      for (int i = 0; i < 20 && !busy; i++) begin
        @(posedge clk);
        #1;
      end
      irq_force = 1'b0;
    end else begin
      hw_set = f;
      @(posedge clk);
      #1;
      hw_set = 4'd0;
    end
  endtask

  task automatic wait_idle(input string name);
    logic seen = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
      else if (seen && !irq) done = 1'b1;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Expected transactions of one service, from the flag/config rules.
  task automatic model_check(input string name, input logic [3:0] f,
                             input logic [13:0] base, input logic [7:0] words);
    logic [13:0] exp_rd[$];
    logic [32:0] exp_out[$];
    int          nev;
    exp_rd.push_back(FLAG_ADDR);
    nev = (f != 4'd0) ? 1 : 0;
    if (f[0] && words != 8'd0) begin
      for (int i = 0; i < int'(words); i++) begin
        logic [13:0] a;
        a = base + 14'(i);
        exp_rd.push_back(a);
        exp_out.push_back({(i == int'(words) - 1), ram_word(a)});
      end
    end
    check({name, "_nrd"}, 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check({name, "_rdaddr"}, 64'(rd_log[i]), 64'(exp_rd[i]));
    check({name, "_nev"}, 64'(ev_log.size()), 64'(nev));
    if (nev != 0 && ev_log.size() > 0) check({name, "_evflags"}, 64'(ev_log[0]), 64'(f));
    check({name, "_nwr"}, 64'(wr_log.size()), 64'(nev));
    if (nev != 0 && wr_log.size() > 0)
      check({name, "_wr"}, 64'(wr_log[0]), 64'({FLAG_ADDR, 32'(f) << 8}));
    check({name, "_nout"}, 64'(out_log.size()), 64'(exp_out.size()));
    for (int i = 0; i < out_log.size() && i < exp_out.size(); i++)
      check({name, "_out"}, 64'(out_log[i]), 64'(exp_out[i]));
  endtask

  typedef struct {
    logic [3:0]  flags;
    logic [13:0] base;
    logic [7:0]  words;
    logic [31:0] junk;
    int          exp_events;
    logic [31:0] exp_wdata;
    int          exp_words;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #50_0000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h0, 14'h0000, 8'd4, 32'h0000_0000, 0, 32'h0000_0000, 0, 2};
    vecs[1] = '{4'h2, 14'h2000, 8'd4, 32'h0000_0000, 1, 32'h0000_0200, 0, 3};
    vecs[2] = '{4'h1, 14'h2000, 8'd4, 32'h0000_0000, 1, 32'h0000_0100, 4, 15};
    vecs[3] = '{4'h1, 14'h3FFE, 8'd3, 32'h0000_0000, 1, 32'h0000_0100, 3, 12};
    vecs[4] = '{4'hF, 14'h0123, 8'd0, 32'h0000_0000, 1, 32'h0000_0F00, 0, 3};
    vecs[5] = '{4'h9, 14'h0010, 8'd1, 32'hFFFF_F0FF, 1, 32'h0000_0900, 1, 6};
    vecs[6] = '{4'h8, 14'h0200, 8'd5, 32'h1234_50AA, 1, 32'h0000_0800, 0, 3};
    vecs[7] = '{4'h0, 14'h0300, 8'd2, 32'hFFFF_F0FF, 0, 32'h0000_0000, 0, 2};

    // Reset state.
    #12;
    check("rst_bus", 64'({host_cs, host_rd, host_wr, host_addr, host_d4wt,
                          event_valid, out_valid, out_last, busy}), 64'd0);
    check("rst_data", 64'({event_flags, out_data}), 64'd0);
    rst_b = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("rst_idle", 64'(busy), 64'd0);

    // Table-driven services with out_ready held high.
    for (int v = 0; v < 8; v++) begin
      clear_logs();
      buf_base_addr = vecs[v].base;
      buf_words     = vecs[v].words;
      flag_junk     = vecs[v].junk;
      raise(vecs[v].flags);
      wait_idle($sformatf("vec%0d", v));
      check($sformatf("vec%0d_events", v), 64'(ev_log.size()), 64'(vecs[v].exp_events));
      if (wr_log.size() > 0)
        check($sformatf("vec%0d_wdata", v), 64'(wr_log[0][31:0]), 64'(vecs[v].exp_wdata));
      check($sformatf("vec%0d_words", v), 64'(out_log.size()), 64'(vecs[v].exp_words));
      check($sformatf("vec%0d_busy", v), 64'(busy_cycles), 64'(vecs[v].exp_busy));
      model_check($sformatf("vec%0d", v), vecs[v].flags, vecs[v].base, vecs[v].words);
    end
    flag_junk = '0;

    // Backpressure: out_ready low for 5 cycles while word 2 is offered.
    begin
      logic hit = 1'b0;
      clear_logs();
      buf_base_addr = 14'h2000;
      buf_words     = 8'd4;
      raise(4'h1);
      for (int i = 0; i < 100 && !hit; i++) begin
        @(posedge clk);
        #1;
        if (out_log.size() == 1 && out_valid) hit = 1'b1;
      end
      check("bp_reach_word2", 64'(hit), 64'd1);
      ready_force = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ready_force = 1'b1;
      wait_idle("bp");
      check("bp_busy", 64'(busy_cycles), 64'd20);
      model_check("bp", 4'h1, 14'h2000, 8'd4);
    end

    // Flag re-set by hardware during the clear write: serviced again.
    begin
      logic hit = 1'b0;
      clear_logs();
      buf_base_addr = 14'h0100;
      buf_words     = 8'd2;
      raise(4'h2);
      for (int i = 0; i < 20 && !hit; i++) begin
        @(posedge clk);
        #1;
        if (host_wr) hit = 1'b1;
      end
      check("race_wr_seen", 64'(hit), 64'd1);
      hw_set = 4'h1;
      @(posedge clk);
      #1;
      hw_set = 4'h0;
      wait_idle("race");
      check("race_nev", 64'(ev_log.size()), 64'd2);
      if (ev_log.size() == 2) begin
        check("race_ev0", 64'(ev_log[0]), 64'h2);
        check("race_ev1", 64'(ev_log[1]), 64'h1);
      end
      check("race_nwr", 64'(wr_log.size()), 64'd2);
      if (wr_log.size() == 2) check("race_wr1", 64'(wr_log[1]), 64'({FLAG_ADDR, 32'h100}));
      check("race_nout", 64'(out_log.size()), 64'd2);
      if (out_log.size() == 2)
        check("race_out1", 64'(out_log[1]), 64'({1'b1, ram_word(14'h0101)}));
    end

    // enable dropped mid-sequence: burst completes, no new service starts.
    begin
      int bc;
      clear_logs();
      buf_base_addr = 14'h0040;
      buf_words     = 8'd3;
      raise(4'h1);
      for (int i = 0; i < 10 && !busy; i++) begin
        @(posedge clk);
        #1;
      end
      enable = 1'b0;
      for (int i = 0; i < 100 && busy; i++) begin
        @(posedge clk);
        #1;
      end
      check("en_burst_words", 64'(out_log.size()), 64'd3);
      bc = busy_cycles;
      raise(4'h2);
      repeat (8) @(posedge clk);
      #1;
      check("en_no_start", 64'(busy_cycles), 64'(bc));
      check("en_no_event", 64'(ev_log.size()), 64'd1);
      enable = 1'b1;
      wait_idle("en");
      check("en_resumed", 64'(ev_log.size()), 64'd2);
      if (ev_log.size() == 2) check("en_ev1", 64'(ev_log[1]), 64'h2);
    end

    // Reset mid-burst: outputs clear asynchronously.
    begin
      logic hit = 1'b0;
      clear_logs();
      buf_base_addr = 14'h0500;
      buf_words     = 8'd8;
      raise(4'h1);
      for (int i = 0; i < 100 && !hit; i++) begin
        @(posedge clk);
        #1;
        if (out_log.size() >= 2) hit = 1'b1;
      end
      check("mid_rst_reach", 64'(hit), 64'd1);
      @(posedge clk);
      #3;
      rst_b = 1'b0;
      #1;
      check("mid_rst_bus", 64'({host_cs, host_rd, host_wr, host_addr, host_d4wt,
                                event_valid, out_valid, out_last, busy}), 64'd0);
      check("mid_rst_data", 64'({event_flags, out_data}), 64'd0);
      #20;
      rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_idle", 64'(busy), 64'd0);
    end

    // Randomized services with random backpressure.
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  f;
      logic [13:0] base;
      logic [7:0]  words;
      f     = 4'($urandom_range(0, 15));
      words = 8'($urandom_range(0, 6));
      base  = (it % 4 == 0) ? 14'h3FFF - 14'($urandom_range(0, 3)) : 14'($urandom);
      clear_logs();
      buf_base_addr = base;
      buf_words     = words;
      flag_junk     = $urandom & ~32'h0000_0F00;
      raise(f);
      wait_idle($sformatf("rnd%0d", it));
      model_check($sformatf("rnd%0d", it), f, base, words);
    end
    rand_ready = 1'b0;

    check("protocol", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
